inst_sram_axi_rd_bridge: RTL and testbench

Converts the instruction-fetch SRAM-like request/response interface driven by the IF stage (req/addr_ok/data_ok) into an AXI4 read-only master: AR and R channels only. It sits directly downstream of the IF stage's instruction-memory port and upstream of the AXI crossbar. It supports a bounded number of in-order outstanding reads. IF-side cancellation is handled in IF; the bridge returns every accepted read.

---
 rtl/inst_sram_axi_rd_bridge.sv | 121 ++++++++++++
 tb/tb_inst_sram_axi_rd_bridge.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_sram_axi_rd_bridge.sv
// inst_sram_axi_rd_bridge
//   Bridges the IF-stage instruction SRAM-like port (req/addr_ok/data_ok)
//   onto an AXI4 read-only master (AR + R channels). Single-beat reads,
//   in-order, with up to MAX_OUTSTANDING accepted-but-unreturned reads.
//   The bridge holds no read data; R data is passed straight through.
//
// Ports
//   clk, resetn             system clock, async active-low reset
//   inst_sram_req/wr/size/addr/wstrb/wdata   IF request side (wstrb/wdata unused)
//   inst_sram_addr_ok       request accepted this cycle
//   inst_sram_data_ok       read data valid this cycle (one-cycle pulse)
//   inst_sram_rdata         read data, meaningful only with data_ok
//   ar*                     AXI read address channel (single beat, INCR)
//   rid/rdata/rresp/rlast/rvalid/rready      AXI read data channel
//   busy                    AR pending or reads outstanding
//   bus_err                 sticky error flag, cleared only by reset
module inst_sram_axi_rd_bridge #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [3:0]  AXI_ID          = 4'd0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic        busy,
  output logic        bus_err
);

  localparam int unsigned      CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  logic [CNT_W-1:0] outstanding;
  logic             have_out;
  logic             accept;
  logic             retire;
  logic             unused_ok;

  // Responses are assumed in order, so rid carries no information here.
  assign unused_ok = ^{inst_sram_wstrb, inst_sram_wdata, rid};

  assign arid    = AXI_ID;
  assign arlen   = 8'd0;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign rready  = 1'b1;

  assign have_out = (outstanding != '0);

  // Gated by resetn so the IF side sees no handshakes while in reset.
  assign accept = resetn & inst_sram_req & ~inst_sram_wr & ~arvalid
                & (outstanding < MAX_CNT);
  assign inst_sram_addr_ok = accept;

  // A beat arriving with nothing outstanding is dropped, not forwarded.
  assign inst_sram_data_ok = resetn & rvalid & have_out;
  assign inst_sram_rdata   = rdata;

  assign retire = rvalid & rready & rlast & have_out;

  assign busy = arvalid | have_out;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      arvalid <= 1'b0;
      araddr  <= 32'd0;
      arsize  <= 3'd0;
    end else if (accept) begin
      arvalid <= 1'b1;
      araddr  <= inst_sram_addr;
      arsize  <= {1'b0, inst_sram_size};
    end else if (arvalid && arready) begin
      arvalid <= 1'b0;
    end
  end

  // Accept and retire in the same cycle cancel out.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      outstanding <= '0;
    end else if (accept && !retire) begin
      outstanding <= outstanding + CNT_W'(1);
    end else if (retire && !accept) begin
      outstanding <= outstanding - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus_err <= 1'b0;
    end else if ((rvalid && (!have_out || rresp != 2'b00)) ||
                 (inst_sram_req && inst_sram_wr)) begin
      bus_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_inst_sram_axi_rd_bridge.sv
// tb_inst_sram_axi_rd_bridge
//   Directed cycle-by-cycle stimulus. The bench plays the AXI slave: every
//   AR handshake queues its address, and R beats return mem_f(address).
//   Every accepted IF request queues mem_f(request address) as expected
//   data; each data_ok pops and compares it.
module tb_inst_sram_axi_rd_bridge;

  logic        clk;
  logic        resetn;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic        busy;
  logic        bus_err;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_q[$];
  logic [31:0] ar_q[$];

  inst_sram_axi_rd_bridge #(.MAX_OUTSTANDING(2), .AXI_ID(4'd0)) dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_addr(inst_sram_addr),
    .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready), .busy(busy), .bus_err(bus_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    if (a == 32'h1c00_0000) return 32'h0280_0c0c;
    return a ^ 32'hdead_beef;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs are driven 1ns after posedge; sampling 2ns later keeps clear of edges.
  task automatic sample_cycle();
    #2;
    if (inst_sram_addr_ok) exp_q.push_back(mem_f(inst_sram_addr));
    if (arvalid && arready) ar_q.push_back(araddr);
    if (inst_sram_data_ok) begin
      if (exp_q.size() == 0) check_val("sb_unexpected_data_ok", 32'd1, 32'd0);
      else check_val("sb_rdata", inst_sram_rdata, exp_q.pop_front());
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    inst_sram_req = 1'b0;
    inst_sram_wr  = 1'b0;
    rvalid        = 1'b0;
    rresp         = 2'b00;
    arready       = 1'b1;
  endtask

  task automatic drive_beat(input logic [1:0] resp);
    rvalid = 1'b1;
    rresp  = resp;
    if (ar_q.size() == 0) begin
      check_val("slave_no_ar_pending", 32'd0, 32'd1);
      rdata = 32'd0;
    end else begin
      rdata = mem_f(ar_q.pop_front());
    end
  endtask

  task automatic fetch(input logic [31:0] a);
    inst_sram_req  = 1'b1;
    inst_sram_addr = a;
  endtask

  initial begin
    resetn          = 1'b0;
    inst_sram_size  = 2'd2;
    inst_sram_addr  = 32'd0;
    inst_sram_wstrb = 4'hf;
    inst_sram_wdata = 32'h1234_5678;
    rid             = 4'd0;
    rdata           = 32'd0;
    rlast           = 1'b1;
    set_idle();

    // ---- reset state, with req and rvalid active
    inst_sram_req = 1'b1;
    rvalid        = 1'b1;
    #3;
    check_val("rst_addr_ok", inst_sram_addr_ok, 0);
    check_val("rst_data_ok", inst_sram_data_ok, 0);
    check_val("rst_arvalid", arvalid, 0);
    check_val("rst_araddr", araddr, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_bus_err", bus_err, 0);
    set_idle();
    repeat (2) next_cycle();
    resetn = 1'b1;
    next_cycle();

    // ---- single fetch
    fetch(32'h1c00_0000);
    sample_cycle();
    check_val("single_addr_ok", inst_sram_addr_ok, 1);
    next_cycle();
    inst_sram_req = 1'b0;
    sample_cycle();
    check_val("single_arvalid", arvalid, 1);
    check_val("single_araddr", araddr, 32'h1c00_0000);
    check_val("single_arsize", arsize, 3'd2);
    check_val("single_const", {arid, arlen, arburst, arlock, arcache, arprot, rready},
              {4'd0, 8'd0, 2'b01, 2'b00, 4'd0, 3'd0, 1'b1});
    next_cycle();
    sample_cycle();
    check_val("single_wait_busy", busy, 1);
    check_val("single_wait_arvalid", arvalid, 0);
    next_cycle();
    drive_beat(2'b00);
    sample_cycle();
    check_val("single_data_ok", inst_sram_data_ok, 1);
    check_val("single_rdata", inst_sram_rdata, 32'h0280_0c0c);
    next_cycle();
    set_idle();
    sample_cycle();
    check_val("single_busy_done", busy, 0);
    check_val("single_bus_err", bus_err, 0);
    check_val("single_data_ok_pulse", inst_sram_data_ok, 0);
    next_cycle();

    // ---- AR backpressure: arready low for 3 cycles
    fetch(32'h1c00_0010);
    arready = 1'b0;
    sample_cycle();
    check_val("bp_addr_ok_first", inst_sram_addr_ok, 1);
    next_cycle();
    fetch(32'h1c00_0014);
    for (int i = 0; i < 4; i++) begin
      arready = (i == 3);
      sample_cycle();
      check_val("bp_arvalid_held", arvalid, 1);
      check_val("bp_araddr_held", araddr, 32'h1c00_0010);
      check_val("bp_second_blocked", inst_sram_addr_ok, 0);
      next_cycle();
    end
    sample_cycle();
    check_val("bp_second_accept", inst_sram_addr_ok, 1);
    next_cycle();
    inst_sram_req = 1'b0;
    sample_cycle();
    check_val("bp_second_araddr", araddr, 32'h1c00_0014);
    next_cycle();
    for (int i = 0; i < 2; i++) begin
      drive_beat(2'b00);
      sample_cycle();
      check_val("bp_data_ok", inst_sram_data_ok, 1);
      next_cycle();
    end
    set_idle();
    sample_cycle();
    check_val("bp_busy_done", busy, 0);
    next_cycle();

    // ---- full stall with MAX_OUTSTANDING=2
    for (int i = 0; i < 2; i++) begin
      fetch(32'h1c00_0100 + 32'(i * 4));
      sample_cycle();
      check_val("full_fill_accept", inst_sram_addr_ok, 1);
      next_cycle();
      inst_sram_req = 1'b0;
      sample_cycle();
      next_cycle();
    end
    fetch(32'h1c00_0108);
    sample_cycle();
    check_val("full_addr_ok_blocked", inst_sram_addr_ok, 0);
    check_val("full_busy", busy, 1);
    check_val("full_ar_idle", arvalid, 0);
    next_cycle();
    drive_beat(2'b00);
    sample_cycle();
    check_val("full_blocked_on_beat", inst_sram_addr_ok, 0);
    next_cycle();
    rvalid = 1'b0;
    sample_cycle();
    check_val("full_resume", inst_sram_addr_ok, 1);
    next_cycle();
    inst_sram_req = 1'b0;
    sample_cycle();
    next_cycle();
    for (int i = 0; i < 2; i++) begin
      drive_beat(2'b00);
      sample_cycle();
      next_cycle();
    end
    set_idle();
    sample_cycle();
    check_val("full_busy_done", busy, 0);
    next_cycle();

    // ---- simultaneous accept and retire with outstanding=1
    fetch(32'h1c00_0200);
    sample_cycle();
    next_cycle();
    inst_sram_req = 1'b0;
    sample_cycle();
    next_cycle();
    fetch(32'h1c00_0204);
    drive_beat(2'b00);
    sample_cycle();
    check_val("simul_addr_ok", inst_sram_addr_ok, 1);
    check_val("simul_data_ok", inst_sram_data_ok, 1);
    next_cycle();
    set_idle();
    sample_cycle();
    next_cycle();
    sample_cycle();
    check_val("simul_count_one_busy", busy, 1);
    next_cycle();
    drive_beat(2'b00);
    sample_cycle();
    next_cycle();
    set_idle();
    sample_cycle();
    check_val("simul_count_zero_busy", busy, 0);
    next_cycle();

    // ---- error response still delivers data
    fetch(32'h1c00_0300);
    sample_cycle();
    next_cycle();
    inst_sram_req = 1'b0;
    sample_cycle();
    next_cycle();
    drive_beat(2'b10);
    sample_cycle();
    check_val("slverr_data_ok", inst_sram_data_ok, 1);
    next_cycle();
    set_idle();
    sample_cycle();
    check_val("slverr_bus_err", bus_err, 1);
    check_val("slverr_busy", busy, 0);
    next_cycle();

    // ---- reset mid-operation: arvalid=1 and outstanding=1
    fetch(32'h1c00_0400);
    arready = 1'b0;
    sample_cycle();
    next_cycle();
    inst_sram_req = 1'b0;
    sample_cycle();
    check_val("midrst_pre_arvalid", arvalid, 1);
    resetn = 1'b0;
    #1;
    check_val("midrst_arvalid", arvalid, 0);
    check_val("midrst_busy", busy, 0);
    check_val("midrst_bus_err", bus_err, 0);
    exp_q.delete();
    ar_q.delete();
    set_idle();
    next_cycle();
    resetn = 1'b1;
    next_cycle();
    fetch(32'h1c00_0000);
    sample_cycle();
    check_val("postrst_addr_ok", inst_sram_addr_ok, 1);
    next_cycle();
    inst_sram_req = 1'b0;
    sample_cycle();
    next_cycle();
    drive_beat(2'b00);
    sample_cycle();
    check_val("postrst_data_ok", inst_sram_data_ok, 1);
    next_cycle();
    set_idle();
    sample_cycle();
    check_val("postrst_busy", busy, 0);
    check_val("postrst_bus_err", bus_err, 0);
    next_cycle();

    // ---- spurious R beat with nothing outstanding
    rvalid = 1'b1;
    rdata  = 32'hbad0_beef;
    sample_cycle();
    check_val("spur_data_ok", inst_sram_data_ok, 0);
    next_cycle();
    set_idle();
    sample_cycle();
    check_val("spur_bus_err", bus_err, 1);
    check_val("spur_busy", busy, 0);
    next_cycle();

    // ---- write requests are never accepted
    resetn = 1'b0;
    next_cycle();
    resetn = 1'b1;
    next_cycle();
    fetch(32'h1c00_0500);
    inst_sram_wr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample_cycle();
      check_val("wr_addr_ok", inst_sram_addr_ok, 0);
      next_cycle();
    end
    set_idle();
    sample_cycle();
    check_val("wr_bus_err", bus_err, 1);
    check_val("wr_no_ar", arvalid, 0);
    check_val("sb_left_over", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
